clk_en_gen_m: RTL and testbench
===============================

Name: clk_en_gen_m

Overview:
- Parametrised successor to the fixed divide-by-12 toggling clock generator.
- Produces NUM_CH independent fractional-rate single-cycle clock enables from one free-running fabric clock, using phase accumulators.
- Adds a glitch-free double-speed switch, run/halt control, a debug single-step to the next channel-0 tick, and a channel-0 tick counter.
- Sits at top level and feeds enables to the CPU, timer and APU, which all run on the single fabric clock.

Parameters:
- ACC_W, 24, accumulator and increment width in bits.
- NUM_CH, 2, number of enable channels.
- INC_RESET, 24'd703687, reset increment for every channel (4.194304 MHz from 100 MHz at ACC_W=24).

Ports:
- clk  input  1  fabric clock, all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- run  input  1  level; 1 advances all accumulators every cycle.
- step  input  1  one-cycle pulse; in HALT with run=0, advances until the next channel-0 tick.
- inc_i  input  NUM_CH*ACC_W  increment load data; channel c uses slice [c*ACC_W +: ACC_W].
- inc_load  input  NUM_CH  per-channel load strobe for inc_i.
- speed2x_req  input  1  requested double-speed mode.
- speed2x  output  1  active double-speed mode.
- ce_o  output  NUM_CH  per-channel single-cycle enable.
- tick_o  output  NUM_CH  per-channel toggle on each enable (divide-by-2 square wave).
- ce_count  output  32  count of channel-0 enables, wraps at 2^32.
- stepping  output  1  high while the FSM is in STEP.

Behaviour:
- Reset (rst_n=0 at posedge):
  - acc[c]=0, inc[c]=INC_RESET, ce_o=0, tick_o=0.
  - speed2x=0, pending mode=0, ce_count=0, state=HALT, stepping=0.
  - Reset overrides every other input, including mid-step.
- advance = run | (state==STEP).
- Effective increment:
  - inc_eff[c] = speed2x ? min(2*inc[c], 2^ACC_W-1) : inc[c].
  - Doubling is computed at ACC_W+1 bits and saturated to ACC_W bits.
- On a posedge with advance=1:
  - {carry,acc[c]} <= acc[c] + inc_eff[c] (ACC_W+1-bit sum; acc wraps mod 2^ACC_W).
  - ce_o[c] <= carry, so an enable is registered on the same edge as the overflowing add.
- With advance=0: acc holds and ce_o <= 0.
- ce_o is never high for two consecutive cycles unless the overflow repeats. With inc=2^ACC_W-1, ce_o is high every cycle except the cycle following acc=0.
- inc=0: no enables, acc holds.
- tick_o[c] toggles on every edge where ce_o[c] is set to 1.
- ce_count increments on every edge where ce_o[0] is set to 1.
- inc_load[c] at a posedge: inc[c] <= inc_i slice. acc is not cleared. The add on that same edge uses the old inc; the new value applies from the next edge.
- Double-speed switch:
  - speed2x_req is registered into pending every cycle; the latest value wins.
  - speed2x <= pending only on an edge where ce_o[0] is being set to 1, so the switch lands on a tick boundary.
  - The new speed applies from the following add.
  - If req is 1 and ce_o[0] is being set on the same edge as the sampling, speed2x takes the pending value from before this edge; the new req is applied at the next tick.
- FSM states: HALT, STEP. Run mode is the run input itself.
  - HALT -> STEP: step=1 & run=0. No add on this edge.
  - STEP -> HALT: on the edge whose add produces channel-0 carry. Exactly one ce_o[0] pulse results.
  - STEP -> HALT also when run=1 (run then governs advance).
  - step is ignored in STEP or when run=1.
  - All channels advance during STEP.
  - stepping = (state==STEP).
- Combinational logic in the datapath is limited to the saturating doubling and the adder; all outputs are registered.

Test Plan:
- Basic rate (ACC_W=8, NUM_CH=2, INC_RESET=64): reset, run=1 from edge 1 -> ce_o[0] high after edges 4, 8, 12, each for one cycle. tick_o[0] toggles at the same edges. ce_count=3 after edge 12.
- Fractional rate: load inc[1]=96 (ACC_W=8) -> ce_o[1] pulses at edges 3, 6, 8, 11, 14, 16, i.e. a 3,3,2 pattern, averaging 96/256 per cycle.
- Mid-stream load: at ACC_W=8, inc[0]=64, acc=128, assert inc_load with 32 -> that edge adds 64 (acc=192). Subsequent adds use 32, giving the next ce_o[0] 2 edges later.
- Double speed: inc[0]=64, assert speed2x_req mid-period -> speed2x rises on the next ce_o[0] edge. Period then becomes 2 cycles. inc=200 with speed2x -> inc_eff=255.
- Step: run=0, acc=0, inc=64, pulse step -> stepping=1 for 4 cycles, exactly one ce_o[0], then HALT with acc=0. A second step pulse sent during STEP is ignored.
- Reset mid-step: assert rst_n=0 during STEP -> next cycle all outputs 0, state HALT, inc=INC_RESET.

Source files
------------

// File: rtl/clk_en_gen_m.sv
// Multi-channel fractional clock-enable generator: per-channel phase accumulators,
// tick-aligned double-speed switch, run/halt with single-step to the next channel-0 tick.

module clk_en_lane_m #(
  parameter int unsigned           ACC_W     = 24,
  parameter logic [ACC_W-1:0]      INC_RESET = 24'd703687
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance_i,
  input  logic             speed2x_i,
  input  logic             inc_load_i,
  input  logic [ACC_W-1:0] inc_i,
  output logic             ce_d_o,
  output logic             ce_o,
  output logic             tick_o
);
  logic [ACC_W-1:0] inc_q, acc_q, acc_d, inc_eff;
  logic [ACC_W:0]   dbl, sum;
  logic             ce_q, tick_q;

  // Doubling saturates instead of wrapping so 2x never runs slower than 1x.
  assign dbl     = {inc_q, 1'b0};
  assign inc_eff = !speed2x_i ? inc_q : (dbl[ACC_W] ? '1 : dbl[ACC_W-1:0]);
  assign sum     = {1'b0, acc_q} + {1'b0, inc_eff};
  assign ce_d_o  = advance_i & sum[ACC_W];
  assign acc_d   = advance_i ? sum[ACC_W-1:0] : acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inc_q  <= INC_RESET;
      acc_q  <= '0;
      ce_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      // A load takes effect on the next add; this edge still uses the old increment.
      if (inc_load_i) inc_q <= inc_i;
      acc_q  <= acc_d;
      ce_q   <= ce_d_o;
      tick_q <= tick_q ^ ce_d_o;
    end
  end

  assign ce_o   = ce_q;
  assign tick_o = tick_q;
endmodule

module clk_en_gen_m #(
  parameter int unsigned           ACC_W     = 24,
  parameter int unsigned           NUM_CH    = 2,
  parameter logic [ACC_W-1:0]      INC_RESET = 24'd703687
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    step,
  input  logic [NUM_CH*ACC_W-1:0] inc_i,
  input  logic [NUM_CH-1:0]       inc_load,
  input  logic                    speed2x_req,
  output logic                    speed2x,
  output logic [NUM_CH-1:0]       ce_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [31:0]             ce_count,
  output logic                    stepping
);
  typedef enum logic {HALT, STEP} state_e;

  state_e              state_q, state_d;
  logic                advance, ce0_d;
  logic                pend_q, speed2x_q, speed2x_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [NUM_CH-1:0]   ce_d;

  assign advance = run | (state_q == STEP);
  assign ce0_d   = ce_d[0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    clk_en_lane_m #(.ACC_W(ACC_W), .INC_RESET(INC_RESET)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance_i (advance),
      .speed2x_i (speed2x_q),
      .inc_load_i(inc_load[c]),
      .inc_i     (inc_i[c*ACC_W +: ACC_W]),
      .ce_d_o    (ce_d[c]),
      .ce_o      (ce_o[c]),
      .tick_o    (tick_o[c])
    );
  end

  always_comb begin
    state_d   = state_q;
    // Mode changes only on a channel-0 tick so no period is ever shortened mid-way.
    speed2x_d = ce0_d ? pend_q : speed2x_q;
    cnt_d     = cnt_q + {31'd0, ce0_d};
    case (state_q)
      HALT:    if (step && !run) state_d = STEP;
      STEP:    if (run || ce0_d) state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= HALT;
      pend_q    <= 1'b0;
      speed2x_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= speed2x_req;
      speed2x_q <= speed2x_d;
      cnt_q     <= cnt_d;
    end
  end

  assign speed2x  = speed2x_q;
  assign ce_count = cnt_q;
  assign stepping = (state_q == STEP);
endmodule

// File: tb/tb_clk_en_gen_m.sv
// Directed bench for clk_en_gen_m at ACC_W=8, NUM_CH=2, INC_RESET=64.

module tb_clk_en_gen_m;
  localparam int AW = 8;
  localparam int NC = 2;

  logic             clk = 1'b0;
  logic             rst_n, run, step, speed2x_req, speed2x, stepping;
  logic [NC*AW-1:0] inc_i;
  logic [NC-1:0]    inc_load, ce_o, tick_o;
  logic [31:0]      ce_count;
  int               errs = 0;
  int               nchk = 0;

  clk_en_gen_m #(.ACC_W(AW), .NUM_CH(NC), .INC_RESET(8'd64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .step       (step),
    .inc_i      (inc_i),
    .inc_load   (inc_load),
    .speed2x_req(speed2x_req),
    .speed2x    (speed2x),
    .ce_o       (ce_o),
    .tick_o     (tick_o),
    .ce_count   (ce_count),
    .stepping   (stepping)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ce"},    ce_o,     0);
    chk({tag, "_tick"},  tick_o,   0);
    chk({tag, "_cnt"},   ce_count, 0);
    chk({tag, "_s2x"},   speed2x,  0);
    chk({tag, "_step"},  stepping, 0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; speed2x_req = 1'b0;
    inc_i = '0; inc_load = '0;
    cyc();
    chk_reset("rst0");

    // Basic rate: inc=64 on both channels -> enable every 4th edge
    rst_n = 1'b1; run = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      cyc();
      chk("basic_ce",   ce_o,   (e % 4 == 0) ? 2'b11 : 2'b00);
      chk("basic_tick", tick_o, ((e / 4) % 2 == 1) ? 2'b11 : 2'b00);
    end
    chk("basic_cnt", ce_count, 3);

    // Fractional: ch1 inc=96 -> 3,3,2 pattern; load while halted
    run = 1'b0; inc_i = {8'd96, 8'd0}; inc_load = 2'b10;
    cyc();
    chk("frac_hold_ce", ce_o, 0);
    inc_load = '0; run = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      cyc();
      chk("frac_ce", ce_o, {1'(e inside {3, 6, 8, 11, 14, 16}), 1'(e % 4 == 0)});
    end
    chk("frac_cnt", ce_count, 7);

    // Mid-stream load: acc0 -> 128, then load 32; that edge still adds 64
    cyc(); chk("mid_a", ce_o[0], 0);
    cyc(); chk("mid_b", ce_o[0], 0);
    inc_i = {8'd96, 8'd32}; inc_load = 2'b01;
    cyc(); chk("mid_load", ce_o[0], 0);
    inc_load = '0;
    cyc(); chk("mid_p1", ce_o[0], 0);
    cyc(); chk("mid_p2", ce_o[0], 1);
    chk("mid_cnt", ce_count, 8);

    // Double speed: restore inc0=64, request mid-period
    run = 1'b0; inc_i = {8'd96, 8'd64}; inc_load = 2'b01;
    cyc();
    inc_load = '0; run = 1'b1;
    cyc(); chk("dbl_e1_s2x", speed2x, 0);
    speed2x_req = 1'b1;
    cyc(); chk("dbl_e2_s2x", speed2x, 0);
    cyc(); chk("dbl_e3_s2x", speed2x, 0);
    cyc(); chk("dbl_e4_s2x", speed2x, 1); chk("dbl_e4_ce", ce_o[0], 1);
    for (int e = 5; e <= 8; e++) begin
      cyc(); chk("dbl_ce", ce_o[0], (e % 2 == 0) ? 1 : 0);
    end
    chk("dbl_cnt", ce_count, 11);

    // Saturation: inc=200 doubled -> 255, carry every cycle except after acc=0
    run = 1'b0; inc_i = {8'd96, 8'd200}; inc_load = 2'b01;
    cyc();
    inc_load = '0; run = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      cyc(); chk("sat_ce", ce_o[0], (e == 1) ? 0 : 1);
    end
    chk("sat_cnt", ce_count, 15);
    chk("sat_s2x", speed2x, 1);

    // Reset clears speed mode and counters
    rst_n = 1'b0; run = 1'b0; speed2x_req = 1'b0;
    cyc();
    chk_reset("rst1");
    rst_n = 1'b1;

    // Single step: 4 edges in STEP, one enable, second step ignored
    step = 1'b1;
    cyc();
    chk("stepA_enter", stepping, 1); chk("stepA_enter_ce", ce_o[0], 0);
    step = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) step = 1'b1;
      cyc();
      step = 1'b0;
      chk("stepA_ce",   ce_o[0],  (i == 4) ? 1 : 0);
      chk("stepA_flag", stepping, (i < 4) ? 1 : 0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("stepA_halt_ce",   ce_o[0],  0);
      chk("stepA_halt_flag", stepping, 0);
    end
    chk("stepA_cnt",  ce_count, 1);
    chk("stepA_tick", tick_o,   2'b11);

    // Reset during STEP: acc started at 0, so no carry through edge 3
    step = 1'b1;
    cyc();
    step = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("stepC_flag", stepping, 1);
      chk("stepC_ce",   ce_o[0],  0);
    end
    rst_n = 1'b0;
    cyc();
    chk_reset("rst2");
    rst_n = 1'b1; run = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      cyc(); chk("post_rst_ce", ce_o, (e == 4) ? 2'b11 : 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
